// File: rtl/fir_sched_ctrl.sv
// Sequencer for the FIR datapath: downloads symmetric coefficients, paces
// input samples into the filter and forwards results to the output FIFO.
module fir_sched_ctrl #(
    parameter int HALF_TAPS   = 50,
    parameter int SAMPLE_DIV  = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        coef_valid,
    output logic        coef_ready,
    input  logic [15:0] coef_data,
    input  logic        coef_reload,
    output logic        fir_coef_valid,
    output logic [5:0]  fir_coef_idx,
    output logic [15:0] fir_coef_data,
    input  logic        fir_coef_done,
    input  logic        in_fifo_empty,
    output logic        in_fifo_rd_en,
    input  logic [15:0] in_fifo_dout,
    output logic        fir_en,
    output logic [15:0] fir_xin,
    input  logic        fir_valid,
    input  logic [15:0] fir_yout,
    input  logic        out_fifo_full,
    output logic        out_fifo_wr_en,
    output logic [15:0] out_fifo_din,
    output logic        busy,
    output logic [15:0] sample_cnt,
    output logic        drop_err,
    output logic        ack_err,
    output logic [2:0]  o_dbg_state
);

    // Handshakes: a coefficient word transfers on a clock edge where
    // coef_valid && coef_ready; the input FIFO pops on an edge with
    // in_fifo_rd_en high and presents the word in the following cycle.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_RUN_IDLE  = 3'd3,
        S_RUN_FETCH = 3'd4,
        S_RUN_EN    = 3'd5,
        S_ERR       = 3'd6
    } state_t;

    localparam int PACE_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int TO_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [5:0]        LAST_IDX  = 6'(HALF_TAPS - 1);
    localparam logic [PACE_W-1:0] LAST_PACE = PACE_W'(SAMPLE_DIV - 1);
    localparam logic [TO_W-1:0]   LAST_TO   = TO_W'(ACK_TIMEOUT - 1);

    state_t             r_state;
    logic [5:0]         r_idx;
    logic [PACE_W-1:0]  r_pace;
    logic [TO_W-1:0]    r_to;
    logic               r_reload_pending;
    logic               r_coef_valid;
    logic [5:0]         r_coef_idx;
    logic [15:0]        r_coef_data;
    logic               r_fir_en;
    logic [15:0]        r_xin;
    logic [15:0]        r_sample_cnt;
    logic               r_ack_err;
    logic               r_wr_en;
    logic [15:0]        r_dout;
    logic               r_drop_err;

    logic w_run;
    logic w_fetch;
    logic w_coef_hs;

    assign w_run = (r_state == S_RUN_IDLE) || (r_state == S_RUN_FETCH) ||
                   (r_state == S_RUN_EN);
    // A pending reload takes priority over fetching a new sample.
    assign w_fetch = (r_state == S_RUN_IDLE) && !r_reload_pending &&
                     !in_fifo_empty && !out_fifo_full && !rst;
    assign w_coef_hs = coef_valid && coef_ready;

    assign coef_ready     = (r_state == S_LOAD);
    assign in_fifo_rd_en  = w_fetch;
    assign busy           = (r_state != S_IDLE);
    assign o_dbg_state    = r_state;
    assign fir_coef_valid = r_coef_valid;
    assign fir_coef_idx   = r_coef_idx;
    assign fir_coef_data  = r_coef_data;
    assign fir_en         = r_fir_en;
    assign fir_xin        = r_xin;
    assign sample_cnt     = r_sample_cnt;
    assign ack_err        = r_ack_err;
    assign out_fifo_wr_en = r_wr_en;
    assign out_fifo_din   = r_dout;
    assign drop_err       = r_drop_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_idx            <= '0;
            r_pace           <= '0;
            r_to             <= '0;
            r_reload_pending <= 1'b0;
            r_coef_valid     <= 1'b0;
            r_coef_idx       <= '0;
            r_coef_data      <= '0;
            r_fir_en         <= 1'b0;
            r_xin            <= '0;
            r_sample_cnt     <= '0;
            r_ack_err        <= 1'b0;
        end else begin
            // The RUN_IDLE branch below clears the flag and wins when both happen.
            if (coef_reload && w_run) begin
                r_reload_pending <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_coef_hs) begin
                        r_coef_data  <= coef_data;
                        r_coef_idx   <= r_idx;
                        r_coef_valid <= 1'b1;
                        r_idx        <= r_idx + 6'd1;
                        if (r_idx == LAST_IDX) begin
                            r_to    <= '0;
                            r_state <= S_WAIT_ACK;
                        end
                    end
                end
                S_WAIT_ACK: begin
                    if (fir_coef_done) begin
                        r_coef_valid <= 1'b0;
                        r_sample_cnt <= '0;
                        r_state      <= S_RUN_IDLE;
                    end else if (r_to == LAST_TO) begin
                        r_ack_err    <= 1'b1;
                        r_coef_valid <= 1'b0;
                        r_state      <= S_ERR;
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
                end
                S_RUN_IDLE: begin
                    if (r_reload_pending) begin
                        r_reload_pending <= 1'b0;
                        r_idx            <= '0;
                        r_state          <= S_LOAD;
                    end else if (w_fetch) begin
                        r_state <= S_RUN_FETCH;
                    end
                end
                S_RUN_FETCH: begin
                    r_xin    <= in_fifo_dout;
                    r_fir_en <= 1'b1;
                    r_pace   <= '0;
                    r_state  <= S_RUN_EN;
                end
                S_RUN_EN: begin
                    if (r_pace == LAST_PACE) begin
                        r_fir_en     <= 1'b0;
                        r_sample_cnt <= r_sample_cnt + 16'd1;
                        r_state      <= S_RUN_IDLE;
                    end else begin
                        r_pace <= r_pace + 1'b1;
                    end
                end
                S_ERR: begin
                    r_coef_valid <= 1'b0;
                    r_fir_en     <= 1'b0;
                    if (start) begin
                        r_ack_err <= 1'b0;
                        r_idx     <= '0;
                        r_state   <= S_LOAD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Result path runs regardless of sequencer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en    <= 1'b0;
            r_dout     <= '0;
            r_drop_err <= 1'b0;
        end else begin
            r_wr_en <= fir_valid && !out_fifo_full;
            if (fir_valid && !out_fifo_full) begin
                r_dout <= fir_yout;
            end
            if (fir_valid && out_fifo_full) begin
                r_drop_err <= 1'b1;
            end
        end
    end

endmodule
